cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 136 +++++++++++++
 tb/tb_cycle_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// ============================================================================
// cycle_sequencer : eight-subcycle machine-cycle sequencer driven by PH2 edges,
//                   with M2 wait-state insertion, timeout and overlap detection.
// Revision 1.0
// ============================================================================
`default_nettype none

module cycle_sequencer (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PH1,
   input  logic       PH2,
   input  logic       WAIT,
   output logic [2:0] SUBCYC,
   output logic       SYNC,
   output logic       ADDR_OE,
   output logic       OPR_STB,
   output logic       OPA_STB,
   output logic       CYC_DONE,
   output logic [3:0] WAIT_CNT,
   output logic       TIMEOUT,
   output logic       OVL_ERR
);

   typedef enum logic [2:0] {
      S_A1 = 3'd0,
      S_A2 = 3'd1,
      S_A3 = 3'd2,
      S_M1 = 3'd3,
      S_M2 = 3'd4,
      S_X1 = 3'd5,
      S_X2 = 3'd6,
      S_X3 = 3'd7
   } subcyc_t;

   localparam logic [3:0] C_WAIT_MAX = 4'd15;

   subcyc_t    r_state;
   subcyc_t    w_state_nxt;
   logic       r_ph2_q;
   logic [3:0] r_wait_cnt;
   logic [3:0] w_wait_cnt_nxt;
   logic       r_timeout;
   logic       w_timeout_nxt;
   logic       r_opr_stb;
   logic       r_opa_stb;
   logic       r_cyc_done;
   logic       w_opr_nxt;
   logic       w_opa_nxt;
   logic       w_done_nxt;
   logic       r_ovl_err;
   logic       w_overlap;
   logic       w_advance;

   // An overlapping clock swallows the PH2 edge: ph2_q still follows PH2.
   assign w_overlap = PH1 & PH2;
   assign w_advance = PH2 & ~r_ph2_q & ~w_overlap;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_A1;
         r_ph2_q    <= 1'b1;
         r_wait_cnt <= 4'd0;
         r_timeout  <= 1'b0;
         r_opr_stb  <= 1'b0;
         r_opa_stb  <= 1'b0;
         r_cyc_done <= 1'b0;
         r_ovl_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ph2_q    <= PH2;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
         r_opr_stb  <= w_opr_nxt;
         r_opa_stb  <= w_opa_nxt;
         r_cyc_done <= w_done_nxt;
         if (w_overlap) begin
            r_ovl_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout_nxt  = r_timeout;
      w_opr_nxt      = 1'b0;
      w_opa_nxt      = 1'b0;
      w_done_nxt     = 1'b0;
      if (w_advance) begin
         case (r_state)
            S_A1: w_state_nxt = S_A2;
            S_A2: w_state_nxt = S_A3;
            S_A3: w_state_nxt = S_M1;
            S_M1: begin
               w_state_nxt = S_M2;
               w_opr_nxt   = 1'b1;
            end
            S_M2: begin
               // Stall in M2 until memory is ready or the wait budget runs out.
               if (WAIT && (r_wait_cnt != C_WAIT_MAX)) begin
                  w_wait_cnt_nxt = r_wait_cnt + 4'd1;
               end else begin
                  w_state_nxt = S_X1;
                  w_opa_nxt   = 1'b1;
                  if (WAIT) begin
                     w_timeout_nxt = 1'b1;
                  end
               end
            end
            S_X1: w_state_nxt = S_X2;
            S_X2: w_state_nxt = S_X3;
            S_X3: begin
               w_state_nxt    = S_A1;
               w_wait_cnt_nxt = 4'd0;
               w_timeout_nxt  = 1'b0;
               w_done_nxt     = 1'b1;
            end
            default: w_state_nxt = S_A1;
         endcase
      end
   end

   assign SUBCYC   = r_state;
   assign SYNC     = (r_state == S_X3);
   assign ADDR_OE  = (r_state == S_A1) || (r_state == S_A2) || (r_state == S_A3);
   assign OPR_STB  = r_opr_stb;
   assign OPA_STB  = r_opa_stb;
   assign CYC_DONE = r_cyc_done;
   assign WAIT_CNT = r_wait_cnt;
   assign TIMEOUT  = r_timeout;
   assign OVL_ERR  = r_ovl_err;

endmodule

`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
// ============================================================================
// tb_cycle_sequencer : directed self-checking bench for cycle_sequencer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cycle_sequencer;

   logic       CLK;
   logic       RST;
   logic       PH1;
   logic       PH2;
   logic       WAIT;
   logic [2:0] SUBCYC;
   logic       SYNC;
   logic       ADDR_OE;
   logic       OPR_STB;
   logic       OPA_STB;
   logic       CYC_DONE;
   logic [3:0] WAIT_CNT;
   logic       TIMEOUT;
   logic       OVL_ERR;

   int checks   = 0;
   int failures = 0;
   int opr_n    = 0;
   int opa_n    = 0;
   int done_n   = 0;

   cycle_sequencer dut (
      .CLK      (CLK),
      .RST      (RST),
      .PH1      (PH1),
      .PH2      (PH2),
      .WAIT     (WAIT),
      .SUBCYC   (SUBCYC),
      .SYNC     (SYNC),
      .ADDR_OE  (ADDR_OE),
      .OPR_STB  (OPR_STB),
      .OPA_STB  (OPA_STB),
      .CYC_DONE (CYC_DONE),
      .WAIT_CNT (WAIT_CNT),
      .TIMEOUT  (TIMEOUT),
      .OVL_ERR  (OVL_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock, sampled 1ns after the edge; strobe pulses are tallied here.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (OPR_STB  === 1'b1) opr_n++;
      if (OPA_STB  === 1'b1) opa_n++;
      if (CYC_DONE === 1'b1) done_n++;
   endtask

   // One PH2 period of four clocks; the advance lands on the third tick.
   task automatic ph2_pulse();
      PH2 = 1'b0;
      tick();
      tick();
      PH2 = 1'b1;
      tick();
      tick();
   endtask

   task automatic clr_cnt();
      opr_n  = 0;
      opa_n  = 0;
      done_n = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_sc;
      RST  = 1'b1;
      PH1  = 1'b0;
      PH2  = 1'b0;
      WAIT = 1'b0;
      tick();
      tick();
      chk("rst_subcyc",   SUBCYC,   0);
      chk("rst_wait_cnt", WAIT_CNT, 0);
      chk("rst_timeout",  TIMEOUT,  0);
      chk("rst_ovl",      OVL_ERR,  0);
      chk("rst_sync",     SYNC,     0);
      chk("rst_addr_oe",  ADDR_OE,  1);
      chk("rst_strobes",  {OPR_STB, OPA_STB, CYC_DONE}, 0);
      RST = 1'b0;

      // Free run through one full machine cycle
      clr_cnt();
      for (int i = 1; i <= 8; i++) begin
         ph2_pulse();
         exp_sc = i % 8;
         chk("free_subcyc",  SUBCYC,  exp_sc);
         chk("free_sync",    SYNC,    (exp_sc == 7) ? 1 : 0);
         chk("free_addr_oe", ADDR_OE, (exp_sc < 3) ? 1 : 0);
      end
      chk("free_opr_n",  opr_n,  1);
      chk("free_opa_n",  opa_n,  1);
      chk("free_done_n", done_n, 1);

      // Three wait states in M2
      for (int i = 0; i < 4; i++) ph2_pulse();
      chk("w3_at_m2", SUBCYC, 4);
      clr_cnt();
      WAIT = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         ph2_pulse();
         chk("w3_hold_subcyc", SUBCYC,   4);
         chk("w3_hold_cnt",    WAIT_CNT, i);
      end
      chk("w3_no_opa_yet", opa_n, 0);
      WAIT = 1'b0;
      ph2_pulse();
      chk("w3_x1",       SUBCYC,   5);
      chk("w3_opa_n",    opa_n,    1);
      chk("w3_cnt_keep", WAIT_CNT, 3);
      chk("w3_timeout",  TIMEOUT,  0);
      for (int i = 0; i < 3; i++) ph2_pulse();
      chk("w3_a1",       SUBCYC,   0);
      chk("w3_cnt_clr",  WAIT_CNT, 0);
      chk("w3_done_n",   done_n,   1);

      // WAIT stuck high: 15 holds then forced exit with TIMEOUT
      for (int i = 0; i < 4; i++) ph2_pulse();
      WAIT = 1'b1;
      clr_cnt();
      for (int i = 0; i < 15; i++) ph2_pulse();
      chk("to_hold_subcyc", SUBCYC,   4);
      chk("to_hold_cnt",    WAIT_CNT, 15);
      chk("to_hold_flag",   TIMEOUT,  0);
      ph2_pulse();
      chk("to_x1",       SUBCYC,   5);
      chk("to_flag",     TIMEOUT,  1);
      chk("to_cnt_sat",  WAIT_CNT, 15);
      chk("to_opa_n",    opa_n,    1);
      ph2_pulse();
      chk("to_flag_x2",  TIMEOUT,  1);
      ph2_pulse();
      chk("to_flag_x3",  TIMEOUT,  1);
      ph2_pulse();
      chk("to_a1",       SUBCYC,   0);
      chk("to_flag_clr", TIMEOUT,  0);
      chk("to_cnt_clr",  WAIT_CNT, 0);
      chk("to_done_n",   done_n,   1);

      // WAIT asserted everywhere except M2 has no effect
      for (int i = 1; i <= 4; i++) begin
         ph2_pulse();
         chk("nw_cnt_pre", WAIT_CNT, 0);
      end
      chk("nw_m2", SUBCYC, 4);
      WAIT = 1'b0;
      ph2_pulse();
      chk("nw_x1", SUBCYC, 5);
      WAIT = 1'b1;
      for (int i = 0; i < 3; i++) ph2_pulse();
      chk("nw_a1",      SUBCYC,   0);
      chk("nw_cnt_end", WAIT_CNT, 0);
      WAIT = 1'b0;

      // Phase overlap on a PH2 rise loses that edge and latches OVL_ERR
      PH2 = 1'b0;
      tick();
      tick();
      PH1 = 1'b1;
      PH2 = 1'b1;
      tick();
      chk("ovl_no_adv", SUBCYC,  0);
      chk("ovl_flag",   OVL_ERR, 1);
      PH1 = 1'b0;
      tick();
      chk("ovl_edge_lost", SUBCYC, 0);
      ph2_pulse();
      chk("ovl_resume", SUBCYC, 1);
      for (int i = 0; i < 7; i++) ph2_pulse();
      chk("ovl_cycle_end", SUBCYC,  0);
      chk("ovl_sticky",    OVL_ERR, 1);

      // Reset in the middle of wait states with PH2 held high
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("ovl_cleared", OVL_ERR, 0);
      for (int i = 0; i < 4; i++) ph2_pulse();
      WAIT = 1'b1;
      for (int i = 0; i < 5; i++) ph2_pulse();
      chk("mr_cnt5", WAIT_CNT, 5);
      clr_cnt();
      RST = 1'b1;
      tick();
      chk("mr_subcyc", SUBCYC,   0);
      chk("mr_cnt",    WAIT_CNT, 0);
      RST  = 1'b0;
      WAIT = 1'b0;
      tick();
      tick();
      chk("mr_no_adv",  SUBCYC, 0);
      chk("mr_no_stb",  opr_n + opa_n + done_n, 0);
      ph2_pulse();
      chk("mr_fresh_edge", SUBCYC, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
